// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: bus widths, field offsets and CSR numbers shared by the EXE, MEM and WB stages.
package cpu_bus_pkg;

  localparam int ES_BUS_W = 231;
  localparam int MS_BUS_W = 234;
  localparam int FWD_W    = 38;

  // EXE->MEM bus layout (LSB first)
  localparam int ES_PC_LSB         = 0;    // 32
  localparam int ES_RESULT_LSB     = 32;   // 32, ALU result / memory address
  localparam int ES_DEST_LSB       = 64;   // 5
  localparam int ES_GR_WE          = 69;
  localparam int ES_RES_FROM_MEM   = 70;
  localparam int ES_MEM_RE         = 71;
  localparam int ES_MEM_WE         = 72;
  localparam int ES_LD_OP_LSB      = 73;   // 5, one-hot
  localparam int ES_EX_LSB         = 78;   // EX_W exception flags
  localparam int ES_HAS_INT        = 94;
  localparam int ES_ERTN           = 95;
  localparam int ES_REFETCH        = 96;
  localparam int ES_CSR_WE         = 97;   // csrwr or csrxchg
  localparam int ES_CSR_NUM_LSB    = 98;   // 14
  localparam int ES_CSR_WMASK_LSB  = 112;  // 32
  localparam int ES_CSR_WVALUE_LSB = 144;  // 32
  localparam int ES_TLBRD          = 176;
  localparam int ES_VADDR_LSB      = 177;  // 32, bad virtual address
  localparam int ES_MISC_LSB       = 209;  // 22, TLB op fields passed through to WB

  localparam int EX_W      = 16;
  localparam int EX_ALE    = 0;
  localparam int EX_ADEM   = 1;
  localparam int EX_TLBR   = 2;
  localparam int EX_PIL    = 3;
  localparam int EX_PIS    = 4;

  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  // MEM->WB: the EXE layout with final_result in the result slot, plus summary flags on top
  localparam int MS_HAS_EX      = 231;
  localparam int MS_WR_ASID_EHI = 232;
  localparam int MS_MEM_OP      = 233;

  // Forwarding bus: ms_valid and gr_we are folded into dest (dest 0 = nothing to bypass,
  // r0 is never a hazard), which is what lets the bus fit in FWD_W.
  localparam int FWD_RESULT_LSB = 0;
  localparam int FWD_DEST_LSB   = 32;
  localparam int FWD_LD_PEND    = 37;

  localparam logic [13:0] CSR_TLBEHI = 14'h11;
  localparam logic [13:0] CSR_ASID   = 14'h18;

  typedef struct packed {
    logic       gr_we;
    logic       res_from_mem;
    logic       mem_re;
    logic       mem_we;
    logic [4:0] ld_op;
    logic       has_int;
    logic       ertn;
    logic       refetch;
    logic       csr_we;
    logic       tlbrd;
  } ms_ctrl_t;

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_align
  import cpu_bus_pkg::*;
(
  input  logic [4:0]  ld_op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] value
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    value = rdata;
    if (ld_op[LD_B])       value = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op[LD_BU]) value = {24'd0, byte_sel};
    else if (ld_op[LD_H])  value = {{16{half_sel[15]}}, half_sel};
    else if (ld_op[LD_HU]) value = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits for data-SRAM responses, aligns load data, hands off to WB.
// Define MEM_STAGE_BYPASS_EN to forward live MEM results to ID instead of stalling on every RAW.
module mem_stage
  import cpu_bus_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                es_to_ms_valid,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  output logic                ms_allowin,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [MS_BUS_W-1:0] ms_to_ws_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                es_req_fire,
  input  logic                wb_flush,
  output logic                ms_ex,
  output logic                ms_ertn,
  output logic                ms_refetch,
  output logic                ms_write_asid_ehi,
  output logic [FWD_W-1:0]    ms_fwd_bus
);
  logic                ms_valid_q;
  logic [ES_BUS_W-1:0] bus_q;
  logic                rbuf_valid_q;
  logic [31:0]         rbuf_data_q;
  logic [1:0]          cancel_cnt_q, cancel_cnt_d;

  ms_ctrl_t    ctrl;
  logic [31:0] result, ld_rdata, ld_value, final_result;
  logic [4:0]  dest;
  logic [13:0] csr_num;
  logic [EX_W-1:0] ex_bits;
  logic mem_op, resp_live, ms_ready_go, ms_leave, load_pending;

  assign result  = bus_q[ES_RESULT_LSB +: 32];
  assign dest    = bus_q[ES_DEST_LSB +: 5];
  assign csr_num = bus_q[ES_CSR_NUM_LSB +: 14];
  assign ex_bits = bus_q[ES_EX_LSB +: EX_W];
  assign ctrl    = '{gr_we: bus_q[ES_GR_WE], res_from_mem: bus_q[ES_RES_FROM_MEM],
                     mem_re: bus_q[ES_MEM_RE], mem_we: bus_q[ES_MEM_WE],
                     ld_op: bus_q[ES_LD_OP_LSB +: 5], has_int: bus_q[ES_HAS_INT],
                     ertn: bus_q[ES_ERTN], refetch: bus_q[ES_REFETCH],
                     csr_we: bus_q[ES_CSR_WE], tlbrd: bus_q[ES_TLBRD]};
  assign mem_op  = ctrl.mem_re | ctrl.mem_we;

  // A response only belongs to this instruction once all responses owed to killed requests drained
  assign resp_live      = data_sram_data_ok & (cancel_cnt_q == 2'd0);
  assign ms_ready_go    = ~mem_op | rbuf_valid_q | resp_live;
  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_leave       = ms_to_ws_valid & ws_allowin;

  always_ff @(posedge clk) begin
    if (reset || wb_flush) ms_valid_q <= 1'b0;
    else if (ms_allowin)   ms_valid_q <= es_to_ms_valid;
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) bus_q <= es_to_ms_bus;
  end

  always_ff @(posedge clk) begin
    if (reset || wb_flush || ms_leave)           rbuf_valid_q <= 1'b0;
    else if (resp_live && ms_valid_q && mem_op)  rbuf_valid_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (resp_live && ms_valid_q && mem_op && !rbuf_valid_q) rbuf_data_q <= data_sram_rdata;
  end

  logic [1:0] cnt_inc;
  logic       cnt_dec;
  logic [2:0] cnt_sum;

  always_comb begin
    cnt_inc = 2'd0;
    if (wb_flush)
      cnt_inc = {1'b0, ms_valid_q & mem_op & ~rbuf_valid_q & ~data_sram_data_ok}
              + {1'b0, es_req_fire & ms_allowin};
    cnt_dec      = data_sram_data_ok & (cancel_cnt_q != 2'd0);
    cnt_sum      = {1'b0, cancel_cnt_q} + {1'b0, cnt_inc} - {2'b00, cnt_dec};
    cancel_cnt_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) cancel_cnt_q <= 2'd0;
    else       cancel_cnt_q <= cancel_cnt_d;
  end

  assign ld_rdata = rbuf_valid_q ? rbuf_data_q : data_sram_rdata;

  load_align u_align (
    .ld_op  (ctrl.ld_op),
    .offset (result[1:0]),
    .rdata  (ld_rdata),
    .value  (ld_value)
  );

  assign final_result = ctrl.res_from_mem ? ld_value : result;

  assign ms_ex             = ms_valid_q & ((|ex_bits) | ctrl.has_int);
  assign ms_ertn           = ms_valid_q & ctrl.ertn;
  assign ms_refetch        = ms_valid_q & ctrl.refetch;
  assign ms_write_asid_ehi = ms_valid_q & ((ctrl.csr_we & ((csr_num == CSR_ASID) |
                                                           (csr_num == CSR_TLBEHI)))
                                           | ctrl.tlbrd);

  always_comb begin
    ms_to_ws_bus                       = '0;
    ms_to_ws_bus[ES_BUS_W-1:0]         = bus_q;
    ms_to_ws_bus[ES_RESULT_LSB +: 32]  = final_result;
    ms_to_ws_bus[MS_HAS_EX]            = ms_ex;
    ms_to_ws_bus[MS_WR_ASID_EHI]       = ms_write_asid_ehi;
    ms_to_ws_bus[MS_MEM_OP]            = mem_op;
  end

`ifdef MEM_STAGE_BYPASS_EN
  assign load_pending = ms_valid_q & ctrl.res_from_mem & ~ms_ready_go;
  assign ms_fwd_bus[FWD_RESULT_LSB +: 32] = final_result;
`else
  assign load_pending = ms_valid_q & ctrl.gr_we;
  assign ms_fwd_bus[FWD_RESULT_LSB +: 32] = 32'd0;
`endif
  assign ms_fwd_bus[FWD_DEST_LSB +: 5] = (ms_valid_q & ctrl.gr_we) ? dest : 5'd0;
  assign ms_fwd_bus[FWD_LD_PEND]       = load_pending;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test-plan steps plus randomized loads/stores checked against an arithmetic model.
`timescale 1ns/1ps
module tb_mem_stage;
  import cpu_bus_pkg::*;

`ifdef MEM_STAGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_ADD = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4, K_LW = 5, K_ST = 6;

  logic                clk = 1'b0;
  logic                reset, es_to_ms_valid, ws_allowin, data_ok, es_req_fire, wb_flush;
  logic [ES_BUS_W-1:0] es_to_ms_bus;
  logic [31:0]         rdata;
  logic                ms_allowin, ms_to_ws_valid, ms_ex, ms_ertn, ms_refetch, ms_wae;
  logic [MS_BUS_W-1:0] ms_to_ws_bus;
  logic [FWD_W-1:0]    ms_fwd_bus;

  int n_cmp = 0, n_bad = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
    .es_req_fire(es_req_fire), .wb_flush(wb_flush), .ms_ex(ms_ex), .ms_ertn(ms_ertn),
    .ms_refetch(ms_refetch), .ms_write_asid_ehi(ms_wae), .ms_fwd_bus(ms_fwd_bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] out_res();
    return ms_to_ws_bus[ES_RESULT_LSB +: 32];
  endfunction

  function automatic logic [ES_BUS_W-1:0] mk(input int kind, input logic [31:0] res,
                                             input logic [4:0] dest);
    logic [ES_BUS_W-1:0] b;
    b = '0;
    b[ES_PC_LSB +: 32]     = 32'h1c00_0000;
    b[ES_RESULT_LSB +: 32] = res;
    b[ES_DEST_LSB +: 5]    = dest;
    b[ES_GR_WE]            = (kind != K_ST);
    b[ES_RES_FROM_MEM]     = (kind >= K_LB && kind <= K_LW);
    b[ES_MEM_RE]           = (kind >= K_LB && kind <= K_LW);
    b[ES_MEM_WE]           = (kind == K_ST);
    case (kind)
      K_LB:    b[ES_LD_OP_LSB + LD_B]  = 1'b1;
      K_LBU:   b[ES_LD_OP_LSB + LD_BU] = 1'b1;
      K_LH:    b[ES_LD_OP_LSB + LD_H]  = 1'b1;
      K_LHU:   b[ES_LD_OP_LSB + LD_HU] = 1'b1;
      K_LW:    b[ES_LD_OP_LSB + LD_W]  = 1'b1;
      default: ;
    endcase
    return b;
  endfunction

  // Reference: what architecturally lands in rd, computed with shifts and two's-complement arithmetic
  function automatic logic [31:0] model(input int kind, input logic [31:0] addr,
                                        input logic [31:0] rd);
    logic [31:0] bv, hv;
    bv = (rd >> (8 * int'(addr[1:0]))) & 32'hFF;
    hv = (rd >> (16 * int'(addr[1]))) & 32'hFFFF;
    case (kind)
      K_LB:    return (bv >= 32'd128)   ? bv - 32'd256   : bv;
      K_LBU:   return bv;
      K_LH:    return (hv >= 32'd32768) ? hv - 32'd65536 : hv;
      K_LHU:   return hv;
      K_LW:    return rd;
      default: return addr;
    endcase
  endfunction

  task automatic enter(input logic [ES_BUS_W-1:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    #1 chk1("enter_allowin", ms_allowin, 1'b1);
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  logic [ES_BUS_W-1:0] tb_bus;

  initial begin
    reset = 1'b1; es_to_ms_valid = 1'b0; ws_allowin = 1'b1; data_ok = 1'b0;
    es_req_fire = 1'b0; wb_flush = 1'b0; rdata = '0; es_to_ms_bus = '0;
    tick(); tick();
    chk1("rst_valid", ms_to_ws_valid, 1'b0);
    chk1("rst_allowin", ms_allowin, 1'b1);
    chk1("rst_ex", ms_ex, 1'b0);
    chk1("rst_ldpend", ms_fwd_bus[FWD_LD_PEND], 1'b0);
    reset = 1'b0;

    // ld.b, data_ok in first MEM cycle
    enter(mk(K_LB, 32'h1003, 5'd4));
    data_ok = 1'b1; rdata = 32'h80FF_1234;
    #1 chk1("ldb_valid", ms_to_ws_valid, 1'b1);
    chk32("ldb_res", out_res(), 32'hFFFF_FF80);
    tick(); data_ok = 1'b0;
    #1 chk1("ldb_gone", ms_to_ws_valid, 1'b0);

    // ld.hu, data_ok three cycles late
    enter(mk(K_LHU, 32'h1002, 5'd6));
    for (int i = 0; i < 3; i++) begin
      #1 chk1("ldhu_wait_valid", ms_to_ws_valid, 1'b0);
      chk1("ldhu_wait_allowin", ms_allowin, 1'b0);
      chk1("ldhu_wait_ldpend", ms_fwd_bus[FWD_LD_PEND], 1'b1);
      tick();
    end
    data_ok = 1'b1; rdata = 32'h8001_0000;
    #1 chk1("ldhu_valid", ms_to_ws_valid, 1'b1);
    chk32("ldhu_res", out_res(), 32'h0000_8001);
    chk1("ldhu_ldpend", ms_fwd_bus[FWD_LD_PEND], !BYP);
    tick(); data_ok = 1'b0;

    // WB stall after data_ok: rbuf must hold the word
    enter(mk(K_LW, 32'h2000, 5'd7));
    ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    #1 chk32("stall_res0", out_res(), 32'hCAFE_F00D);
    tick(); data_ok = 1'b0; rdata = 32'hDEAD_BEEF;
    #1 chk1("stall_valid1", ms_to_ws_valid, 1'b1);
    chk32("stall_res1", out_res(), 32'hCAFE_F00D);
    chk1("stall_allowin1", ms_allowin, 1'b0);
    tick(); ws_allowin = 1'b1;
    #1 chk32("stall_res2", out_res(), 32'hCAFE_F00D);
    chk1("stall_allowin2", ms_allowin, 1'b1);
    tick();
    #1 chk1("stall_gone", ms_to_ws_valid, 1'b0);

    // Flush with a load outstanding, then a flush that kills a freshly accepted request
    enter(mk(K_LW, 32'h3000, 5'd8));
    wb_flush = 1'b1; es_req_fire = 1'b1;
    #1 chk1("fl_allowin", ms_allowin, 1'b0);
    tick(); es_req_fire = 1'b0;
    #1 chk1("fl_cleared", ms_to_ws_valid, 1'b0);
    wb_flush = 1'b1; es_req_fire = 1'b1;
    tick(); wb_flush = 1'b0; es_req_fire = 1'b0;
    enter(mk(K_LB, 32'h4001, 5'd9));
    data_ok = 1'b1; rdata = 32'h1111_1111;
    #1 chk1("fl_drop1", ms_to_ws_valid, 1'b0);
    tick(); rdata = 32'h2222_2222;
    #1 chk1("fl_drop2", ms_to_ws_valid, 1'b0);
    tick(); rdata = 32'h0000_8300;
    #1 chk1("fl_third_valid", ms_to_ws_valid, 1'b1);
    chk32("fl_third_res", out_res(), 32'hFFFF_FF83);
    tick(); data_ok = 1'b0;

    // Reset mid-operation clears the owed-response count
    enter(mk(K_LW, 32'h5000, 5'd10));
    wb_flush = 1'b1;
    tick(); wb_flush = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0;
    enter(mk(K_LW, 32'h5004, 5'd11));
    data_ok = 1'b1; rdata = 32'h0BAD_CAFE;
    #1 chk1("rstcnt_valid", ms_to_ws_valid, 1'b1);
    chk32("rstcnt_res", out_res(), 32'h0BAD_CAFE);
    tick(); data_ok = 1'b0;

    // add.w forwarding
    enter(mk(K_ADD, 32'h1234, 5'd5));
    #1 chk1("add_valid", ms_to_ws_valid, 1'b1);
    chk32("add_res", out_res(), 32'h1234);
    chk32("add_fwd_dest", 32'(ms_fwd_bus[FWD_DEST_LSB +: 5]), 32'd5);
    chk32("add_fwd_res", ms_fwd_bus[FWD_RESULT_LSB +: 32], BYP ? 32'h1234 : 32'h0);
    chk1("add_ldpend", ms_fwd_bus[FWD_LD_PEND], !BYP);
    tick();

    // st.w with ALE still waits for its response
    tb_bus = mk(K_ST, 32'h6001, 5'd0);
    tb_bus[ES_EX_LSB + EX_ALE] = 1'b1;
    enter(tb_bus);
    #1 chk1("ale_wait", ms_to_ws_valid, 1'b0);
    chk1("ale_ex0", ms_ex, 1'b1);
    tick(); data_ok = 1'b1;
    #1 chk1("ale_valid", ms_to_ws_valid, 1'b1);
    chk1("ale_ex1", ms_ex, 1'b1);
    chk1("ale_bus_ex", ms_to_ws_bus[MS_HAS_EX], 1'b1);
    tick(); data_ok = 1'b0;
    #1 chk1("ale_gone_ex", ms_ex, 1'b0);

    // CSR write to ASID, then ertn with interrupt
    tb_bus = mk(K_ADD, 32'h0, 5'd12);
    tb_bus[ES_CSR_WE] = 1'b1;
    tb_bus[ES_CSR_NUM_LSB +: 14] = 14'h18;
    enter(tb_bus);
    #1 chk1("asid_wae", ms_wae, 1'b1);
    chk1("asid_ertn", ms_ertn, 1'b0);
    tick();
    tb_bus = mk(K_ADD, 32'h0, 5'd0);
    tb_bus[ES_ERTN] = 1'b1;
    tb_bus[ES_HAS_INT] = 1'b1;
    enter(tb_bus);
    #1 chk1("ertn_ertn", ms_ertn, 1'b1);
    chk1("ertn_ex", ms_ex, 1'b1);
    chk1("ertn_wae", ms_wae, 1'b0);
    tick();

    // Randomized loads/stores/ALU ops with random response latency and WB stalls
    for (int n = 0; n < 60; n++) begin
      int kind, lat, stall;
      logic [31:0] addr, rd, exp;
      kind  = int'($urandom_range(0, 6));
      addr  = $urandom;
      rd    = $urandom;
      lat   = int'($urandom_range(0, 3));
      stall = int'($urandom_range(0, 2));
      exp   = model(kind, addr, rd);
      enter(mk(kind, addr, 5'(n % 31 + 1)));
      if (kind != K_ADD) begin
        for (int i = 0; i < lat; i++) begin
          #1 chk1("rnd_wait", ms_to_ws_valid, 1'b0);
          tick();
        end
        data_ok = 1'b1; rdata = rd;
      end
      ws_allowin = (stall == 0);
      #1 chk1("rnd_valid", ms_to_ws_valid, 1'b1);
      chk32("rnd_res", out_res(), exp);
      for (int s = 1; s <= stall; s++) begin
        tick(); data_ok = 1'b0; rdata = $urandom; ws_allowin = (s == stall);
        #1 chk1("rnd_hold_valid", ms_to_ws_valid, 1'b1);
        chk32("rnd_hold_res", out_res(), exp);
      end
      tick(); data_ok = 1'b0; ws_allowin = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
